// File: rtl/regfile_mp.sv
// Multi-port RV64I integer register file: NWR write ports, NRD read ports,
// same-cycle bypass, issue-stage busy scoreboard and optional registered read.
module regfile_mp #(
  parameter int XLEN      = 64,
  parameter int REGNUM    = 32,
  parameter int AW        = $clog2(REGNUM),
  parameter int NRD       = 4,
  parameter int NWR       = 2,
  parameter int SYNC_READ = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                bset,
  input  logic [AW-1:0]       bset_addr,
  output logic                wr_conflict
);

  logic [XLEN-1:0]     regs_q [REGNUM];
  logic [XLEN-1:0]     regs_d [REGNUM];
  logic [REGNUM-1:0]   busy_q;
  logic [REGNUM-1:0]   busy_d;
  logic                wr_conflict_q;
  logic                wr_conflict_d;
  logic [NWR-1:0]      wvld;
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0]      rd_busy;
  logic [NRD-1:0]      rd_hit;

  // A write only counts when enabled and not aimed at x0
  always_comb begin
    wvld = '0;
    for (int k = 0; k < NWR; k++) begin
      wvld[k] = we[k] && (waddr[k*AW +: AW] != '0);
    end
  end

  // Ascending port order lets the highest index win on shared addresses
  always_comb begin
    for (int r = 0; r < REGNUM; r++) begin
      regs_d[r] = regs_q[r];
    end
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wvld[k]) begin
        regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
        busy_d[waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (bset && (bset_addr != '0)) begin
      busy_d[bset_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      for (int m = k + 1; m < NWR; m++) begin
        if (wvld[k] && wvld[m] &&
            (waddr[k*AW +: AW] == waddr[m*AW +: AW])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REGNUM; r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < REGNUM; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Read path: bypass from in-flight writes, retiring write clears busy
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    rd_hit  = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_val[j*XLEN +: XLEN] = regs_q[raddr[j*AW +: AW]];
      for (int k = 0; k < NWR; k++) begin
        if (wvld[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
          rd_hit[j]              = 1'b1;
          rd_val[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
        end
      end
      if (raddr[j*AW +: AW] == '0) begin
        rd_val[j*XLEN +: XLEN] = '0;
      end
      rd_busy[j] = busy_q[raddr[j*AW +: AW]] & ~rd_hit[j];
    end
  end

  generate
    if (SYNC_READ != 0) begin : g_sync
      logic [NRD*XLEN-1:0] rdata_q;
      logic [NRD-1:0]      rbusy_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
          rbusy_q <= '0;
        end else begin
          rdata_q <= rd_val;
          rbusy_q <= rd_busy;
        end
      end

      assign rdata = rdata_q;
      assign rbusy = rbusy_q;
    end else begin : g_async
      assign rdata = rd_val;
      assign rbusy = rd_busy;
    end
  endgenerate

  assign wr_conflict = wr_conflict_q;

endmodule
